// File: rtl/mmio_result_port.sv
// ============================================================================
// Module      : mmio_result_port
// Description : Store-bus result checker with a sticky PASS/FAIL/TIMEOUT
//               verdict and a readable status word.
//               Define MMIO_RESULT_DISPLAY_EN for a one-shot simulation message.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_result_port #(
    parameter logic [31:0] RESULT_ADDR    = 32'd100,
    parameter logic [31:0] EXPECTED       = 32'd25,
    parameter logic [31:0] SCRATCH_ADDR   = 32'd96,
    parameter logic [31:0] STATUS_ADDR    = 32'd104,
    parameter int unsigned TIMEOUT_CYCLES = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [1:0]  state,
    output logic        done,
    output logic        pass,
    output logic [15:0] store_count,
    output logic [31:0] fail_addr,
    output logic [31:0] fail_data
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] c_tmo_last = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]   c_cnt_max  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_PASS    = 2'b01,
        ST_FAIL    = 2'b10,
        ST_TIMEOUT = 2'b11
    } state_t;

    state_t        r_state;
    logic          r_done;
    logic          r_pass;
    logic [15:0]   r_store_count;
    logic [31:0]   r_fail_addr;
    logic [31:0]   r_fail_data;
    logic [CW-1:0] r_cycles;

    logic w_hit_pass;
    logic w_hit_fail;

    // Unknown address/data bits fall through to the failing branches.
    always_comb begin
        w_hit_pass = 1'b0;
        w_hit_fail = 1'b0;
        if (MemWrite) begin
            if (DataAdr == RESULT_ADDR) begin
                if (WriteData == EXPECTED) begin
                    w_hit_pass = 1'b1;
                end else begin
                    w_hit_fail = 1'b1;
                end
            end else if (DataAdr == SCRATCH_ADDR) begin
                w_hit_pass = 1'b0;
            end else begin
                w_hit_fail = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_store_count <= 16'd0;
            r_fail_addr   <= 32'd0;
            r_fail_data   <= 32'd0;
            r_cycles      <= '0;
        end else if (r_state == ST_RUN) begin
            r_cycles <= r_cycles + CW'(1);
            if (MemWrite && (r_store_count != c_cnt_max)) begin
                r_store_count <= r_store_count + 16'd1;
            end
            // A deciding store outranks the timeout on the same edge.
            if (w_hit_pass) begin
                r_state <= ST_PASS;
                r_done  <= 1'b1;
                r_pass  <= 1'b1;
`ifdef MMIO_RESULT_DISPLAY_EN
                $display("The verification was successfully completed");
`endif
            end else if (w_hit_fail) begin
                r_state     <= ST_FAIL;
                r_done      <= 1'b1;
                r_fail_addr <= DataAdr;
                r_fail_data <= WriteData;
`ifdef MMIO_RESULT_DISPLAY_EN
                $display("An error has been detected: addr=%h data=%h", DataAdr, WriteData);
`endif
            end else if (r_cycles == c_tmo_last) begin
                r_state <= ST_TIMEOUT;
                r_done  <= 1'b1;
`ifdef MMIO_RESULT_DISPLAY_EN
                $display("Timeout");
`endif
            end
        end
    end

    assign state       = r_state;
    assign done        = r_done;
    assign pass        = r_pass;
    assign store_count = r_store_count;
    assign fail_addr   = r_fail_addr;
    assign fail_data   = r_fail_data;
    assign ReadData    = (DataAdr == STATUS_ADDR) ? {r_store_count, 14'b0, r_state} : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_mmio_result_port.sv
// ============================================================================
// Module      : tb_mmio_result_port
// Description : Directed self-checking bench for mmio_result_port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_result_port;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mw = 1'b0;
    logic [31:0] adr = 32'd0;
    logic [31:0] wd = 32'd0;
    logic [31:0] rd;
    logic [1:0]  st;
    logic        dn, ps;
    logic [15:0] cnt;
    logic [31:0] faddr, fdata;

    logic        mw2 = 1'b0;
    logic [31:0] adr2 = 32'd0;
    logic [31:0] rd2;
    logic [1:0]  st2;
    logic        dn2, ps2;
    logic [15:0] cnt2;
    logic [31:0] faddr2, fdata2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mmio_result_port u_dut (
        .clk(clk), .reset(reset), .MemWrite(mw), .DataAdr(adr), .WriteData(wd),
        .ReadData(rd), .state(st), .done(dn), .pass(ps), .store_count(cnt),
        .fail_addr(faddr), .fail_data(fdata)
    );

    mmio_result_port #(.TIMEOUT_CYCLES(100000)) u_dut_sat (
        .clk(clk), .reset(reset), .MemWrite(mw2), .DataAdr(adr2), .WriteData(32'd0),
        .ReadData(rd2), .state(st2), .done(dn2), .pass(ps2), .store_count(cnt2),
        .fail_addr(faddr2), .fail_data(fdata2)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mw  = 1'b1;
        adr = a;
        wd  = d;
        tick();
        mw  = 1'b0;
        adr = 32'd0;
        wd  = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // reset state, before release
        #20;
        check_vec("rst_state", {30'd0, st}, 32'd0);
        check_vec("rst_done", {31'd0, dn}, 32'd0);
        check_vec("rst_count", {16'd0, cnt}, 32'd0);
        check_vec("rst_faddr", faddr, 32'd0);
        #2;
        reset = 1'b0;

        // scratch then correct result
        store(32'd96, 32'd7);
        check_vec("scratch_state", {30'd0, st}, 32'd0);
        store(32'd100, 32'd25);
        check_vec("pass_state", {30'd0, st}, 32'd1);
        check_vec("pass_pass", {31'd0, ps}, 32'd1);
        check_vec("pass_done", {31'd0, dn}, 32'd1);
        check_vec("pass_count", {16'd0, cnt}, 32'd2);
        adr = 32'd104;
        #1;
        check_vec("status_word", rd, 32'h0002_0001);
        adr = 32'd100;
        #1;
        check_vec("rd_other", rd, 32'd0);
        adr = 32'd0;

        // wrong data at result address, then sticky
        do_reset();
        store(32'd100, 32'd24);
        check_vec("bad_state", {30'd0, st}, 32'd2);
        check_vec("bad_faddr", faddr, 32'd100);
        check_vec("bad_fdata", fdata, 32'd24);
        check_vec("bad_pass", {31'd0, ps}, 32'd0);
        store(32'd100, 32'd25);
        check_vec("sticky_state", {30'd0, st}, 32'd2);
        check_vec("sticky_count", {16'd0, cnt}, 32'd1);

        // illegal address, then async clear from FAIL
        do_reset();
        store(32'd200, 32'd25);
        check_vec("illegal_state", {30'd0, st}, 32'd2);
        check_vec("illegal_faddr", faddr, 32'd200);
        check_vec("illegal_fdata", fdata, 32'd25);
        #3;
        reset = 1'b1;
        #1;
        check_vec("async_fail_faddr", faddr, 32'd0);
        check_vec("async_fail_state", {30'd0, st}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // scratch only for 10 cycles
        for (int i = 0; i < 10; i++) store(32'd96, i);
        check_vec("scratch10_state", {30'd0, st}, 32'd0);
        check_vec("scratch10_count", {16'd0, cnt}, 32'd10);

        // timeout boundary
        do_reset();
        repeat (23) tick();
        check_vec("tmo_edge23", {30'd0, st}, 32'd0);
        tick();
        check_vec("tmo_edge24", {30'd0, st}, 32'd3);
        check_vec("tmo_done", {31'd0, dn}, 32'd1);
        check_vec("tmo_pass", {31'd0, ps}, 32'd0);

        // pass on the final edge wins over timeout
        do_reset();
        repeat (23) tick();
        store(32'd100, 32'd25);
        check_vec("late_pass_state", {30'd0, st}, 32'd1);
        check_vec("late_pass_count", {16'd0, cnt}, 32'd1);

        // async reset while in PASS, then rerun
        #3;
        reset = 1'b1;
        #1;
        check_vec("async_state", {30'd0, st}, 32'd0);
        check_vec("async_pass", {31'd0, ps}, 32'd0);
        check_vec("async_done", {31'd0, dn}, 32'd0);
        check_vec("async_count", {16'd0, cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        store(32'd100, 32'd25);
        check_vec("rerun_state", {30'd0, st}, 32'd1);

        // store counter saturation
        do_reset();
        mw2  = 1'b1;
        adr2 = 32'd96;
        repeat (65535) tick();
        check_vec("sat_reach", {16'd0, cnt2}, 32'h0000_FFFF);
        repeat (70000 - 65535) tick();
        check_vec("sat_hold", {16'd0, cnt2}, 32'h0000_FFFF);
        check_vec("sat_state", {30'd0, st2}, 32'd0);
        mw2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mmio_result_port.md
# mmio_result_port

Memory-mapped result responder on the core's data-store bus, the receiving end of the `MemWrite` / `DataAdr` / `WriteData` stores issued by `top`. It replaces ad hoc bench checking with a synthesizable checker.
- It classifies every store as a result, a permitted scratch store or an illegal store.
- It latches a sticky PASS/FAIL/TIMEOUT verdict.
- It exposes the verdict through status outputs and a readable status word.

## Interface
Parameters:
- `RESULT_ADDR`, 32'd100: address of the result store.
- `EXPECTED`, 32'd25: required result value.
- `SCRATCH_ADDR`, 32'd96: address where stores are permitted and ignored.
- `STATUS_ADDR`, 32'd104: load address returning the status word.
- `TIMEOUT_CYCLES`, 24: RUN-state clock edges allowed before a TIMEOUT verdict.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `MemWrite`  in  1  store strobe from the core.
- `DataAdr`  in  32  store/load address.
- `WriteData`  in  32  store data.
- `ReadData`  out  32  status word when `DataAdr == STATUS_ADDR`, else 0 (combinational).
- `state`  out  2  RUN=00, PASS=01, FAIL=10, TIMEOUT=11.
- `done`  out  1  `state != RUN`.
- `pass`  out  1  `state == PASS`.
- `store_count`  out  16  stores sampled in RUN; saturates at 16'hFFFF.
- `fail_addr`  out  32  `DataAdr` of the offending store.
- `fail_data`  out  32  `WriteData` of the offending store.

## Operation
- Reset value of every register output is 0: state=RUN, `store_count`=0, `fail_addr`=0, `fail_data`=0, internal cycle counter=0.
- Evaluation happens in RUN only, on each rising edge with `MemWrite`=1:
  - `DataAdr==RESULT_ADDR` and `WriteData==EXPECTED` -> PASS.
  - `DataAdr==RESULT_ADDR` and the data differs -> FAIL; latch `fail_addr`/`fail_data`.
  - `DataAdr==SCRATCH_ADDR` -> no verdict.
  - Any other address -> FAIL; latch `fail_addr`/`fail_data`.
  - Comparisons use exact 32-bit equality; an X/Z input is treated as a mismatch and results in FAIL.
- `store_count` increments on every store sampled in RUN, including the store that terminates the run.
- Timeout: the cycle counter increments on every RUN edge. On the edge where it equals `TIMEOUT_CYCLES-1` with no terminal store, the next state is TIMEOUT.
- Terminal states (PASS, FAIL, TIMEOUT) are sticky until reset. Stores seen in terminal states are ignored; counters and latched fields freeze.
- Status word = {`store_count`[15:0], 14'b0, `state`[1:0]}.

## Timing
- Verdict latency: `state`, `done` and `pass` change one rising edge after the deciding store is presented, i.e. they are visible after the same edge that samples it.
- The first edge after `reset` deasserts is a valid evaluation edge; there is no idle cycle.
- Store and timeout on the same edge: the store verdict takes priority (a PASS store at the final cycle yields PASS).
- `reset` asserted mid-run or in a terminal state clears all state immediately without waiting for a clock edge. Release is sampled synchronously.
- `ReadData` follows `DataAdr` combinationally, with zero latency.

## Configuration
- `MMIO_RESULT_DISPLAY_EN`
  - When defined: on entering a terminal state, issue one `$display`:
    - PASS: "The verification was successfully completed".
    - FAIL: "An error has been detected" plus `fail_addr`/`fail_data` in hex.
    - TIMEOUT: "Timeout".
    - The message is simulation-only and printed exactly once per run.
  - When undefined: no system tasks are compiled and the block is fully synthesizable. Functional behaviour is identical.

## Test plan
- Reset held 22 ns, then store (96, 7) followed by store (100, 25) -> state=01, pass=1, done=1, store_count=2; `ReadData` at addr 104 = 32'h0002_0001.
- Store (100, 24) -> state=10, fail_addr=100, fail_data=24; a later store (100, 25) leaves state=10 and store_count=1.
- Store (200, 25) -> FAIL with fail_addr=200. A store to 96 alone over 10 cycles -> state remains 00.
- No stores for 24 edges -> state=11 after edge 24, not before. Store (100, 25) on edge 24 -> PASS instead.
- Assert `reset` between clock edges while in PASS -> all outputs 0 and state=00 immediately, with no clock edge; the run then restarts and reaches PASS again.
- 70000 scratch stores with `TIMEOUT_CYCLES` raised to 100000 -> store_count saturates at 16'hFFFF and does not wrap.
